// File: rtl/alu16_pkg.sv
// ============================================================================
// alu16_pkg : shared op codes, flag bit positions and sequencer states
// Revision  : 1.0
// ============================================================================
`default_nettype none

package alu16_pkg;

  typedef enum logic [2:0] {
    ADD16 = 3'd0,
    ADC16 = 3'd1,
    SBC16 = 3'd2,
    INC16 = 3'd3,
    DEC16 = 3'd4
  } alu16_op;

  // Same F layout as the 8-bit alu status_flag
  localparam int FLAG_S  = 7;
  localparam int FLAG_Z  = 6;
  localparam int FLAG_Y  = 5;
  localparam int FLAG_H  = 4;
  localparam int FLAG_X  = 3;
  localparam int FLAG_PV = 2;
  localparam int FLAG_N  = 1;
  localparam int FLAG_C  = 0;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_LO   = 2'd1,
    ST_HI   = 2'd2,
    ST_DONE = 2'd3
  } seq_state_t;

endpackage

`default_nettype wire

// File: rtl/add8_slice.sv
// ============================================================================
// add8_slice : combinational x + y + cin with half-carry and signed overflow
// Revision   : 1.0
// ============================================================================
`default_nettype none

module add8_slice #(
  parameter int SLICE_WIDTH = 8
) (
  input  logic [SLICE_WIDTH-1:0] x,
  input  logic [SLICE_WIDTH-1:0] y,
  input  logic                   cin,
  output logic [SLICE_WIDTH-1:0] sum,
  output logic                   cout,
  output logic                   c4,
  output logic                   ovf
);

  logic [SLICE_WIDTH:0] full;
  logic [4:0]           low_nib;

  assign full    = {1'b0, x} + {1'b0, y} + {{SLICE_WIDTH{1'b0}}, cin};
  assign low_nib = {1'b0, x[3:0]} + {1'b0, y[3:0]} + {4'b0000, cin};

  assign sum  = full[SLICE_WIDTH-1:0];
  assign cout = full[SLICE_WIDTH];
  assign c4   = low_nib[4];
  assign ovf  = (x[SLICE_WIDTH-1] == y[SLICE_WIDTH-1]) &&
                (sum[SLICE_WIDTH-1] != x[SLICE_WIDTH-1]);

endmodule

`default_nettype wire

// File: rtl/alu_16_sequencer.sv
// ============================================================================
// alu_16_sequencer : Z80 16-bit ADD/ADC/SBC/INC/DEC as two 8-bit passes
// Revision         : 1.0
// ============================================================================
`default_nettype none

module alu_16_sequencer
  import alu16_pkg::*;
#(
  parameter int SLICE_WIDTH = 8,
  parameter int FLAG_WIDTH  = 8
) (
  input  logic                     clk,
  input  logic                     reset_n,
  input  logic                     req_valid,
  output logic                     req_ready,
  input  logic [2:0]               op,
  input  logic [2*SLICE_WIDTH-1:0] a,
  input  logic [2*SLICE_WIDTH-1:0] b,
  input  logic [FLAG_WIDTH-1:0]    flags_in,
  output logic                     rsp_valid,
  output logic [2*SLICE_WIDTH-1:0] result,
  output logic [FLAG_WIDTH-1:0]    flags_out
);

  localparam int W = 2 * SLICE_WIDTH;

  seq_state_t             state, state_nxt;
  logic [2:0]             op_q;
  logic [W-1:0]           a_q, b_q, y_full, res_w;
  logic [FLAG_WIDTH-1:0]  f_q, nf;
  logic [SLICE_WIDTH-1:0] lo_q, hi_q, sx, sy, ssum;
  logic                   c8_q, lo_zero_q, c12_q, c16_q, ovf_q;
  logic                   cin_lo, hi_pass, scin, scout, sc4, sovf;
  logic                   accept;

  assign accept    = req_valid && req_ready;
  assign hi_pass   = (state == ST_HI);
  assign res_w     = {hi_q, lo_q};

  // Subtraction runs as a + ~b + carry, so the carry chain holds NOT borrow
  always_comb begin
    y_full = '0;
    cin_lo = 1'b0;
    case (op_q)
      ADD16:   y_full = b_q;
      ADC16:   begin y_full = b_q;  cin_lo = f_q[FLAG_C];  end
      SBC16:   begin y_full = ~b_q; cin_lo = ~f_q[FLAG_C]; end
      INC16:   y_full = 16'h0001;
      DEC16:   y_full = 16'hFFFF;
      default: y_full = '0;
    endcase
  end

  assign sx   = hi_pass ? a_q[W-1:SLICE_WIDTH]    : a_q[SLICE_WIDTH-1:0];
  assign sy   = hi_pass ? y_full[W-1:SLICE_WIDTH] : y_full[SLICE_WIDTH-1:0];
  assign scin = hi_pass ? c8_q : cin_lo;

  add8_slice #(.SLICE_WIDTH(SLICE_WIDTH)) u_slice (
    .x    (sx),
    .y    (sy),
    .cin  (scin),
    .sum  (ssum),
    .cout (scout),
    .c4   (sc4),
    .ovf  (sovf)
  );

  always_comb begin
    state_nxt = state;
    req_ready = 1'b0;
    case (state)
      ST_IDLE: begin
        req_ready = 1'b1;
        if (req_valid) state_nxt = ST_LO;
      end
      ST_LO:   state_nxt = ST_HI;
      ST_HI:   state_nxt = ST_DONE;
      default: state_nxt = ST_IDLE;
    endcase
  end

  always_comb begin
    nf = f_q;
    if (op_q == ADD16 || op_q == ADC16 || op_q == SBC16) begin
      nf[FLAG_Y] = res_w[13];
      nf[FLAG_X] = res_w[11];
      nf[FLAG_H] = c12_q;
      nf[FLAG_N] = 1'b0;
      nf[FLAG_C] = c16_q;
      if (op_q != ADD16) begin
        nf[FLAG_S]  = res_w[15];
        nf[FLAG_Z]  = lo_zero_q && (hi_q == '0);
        nf[FLAG_PV] = ovf_q;
      end
      if (op_q == SBC16) begin
        nf[FLAG_N] = 1'b1;
        nf[FLAG_H] = ~c12_q;
        nf[FLAG_C] = ~c16_q;
      end
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) state <= ST_IDLE;
    else          state <= state_nxt;
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      op_q      <= '0;
      a_q       <= '0;
      b_q       <= '0;
      f_q       <= '0;
      lo_q      <= '0;
      hi_q      <= '0;
      c8_q      <= 1'b0;
      lo_zero_q <= 1'b0;
      c12_q     <= 1'b0;
      c16_q     <= 1'b0;
      ovf_q     <= 1'b0;
      result    <= '0;
      flags_out <= '0;
      rsp_valid <= 1'b0;
    end else begin
      rsp_valid <= 1'b0;
      if (accept) begin
        op_q <= op;
        a_q  <= a;
        b_q  <= b;
        f_q  <= flags_in;
      end
      case (state)
        ST_LO: begin
          lo_q      <= ssum;
          c8_q      <= scout;
          lo_zero_q <= (ssum == '0);
        end
        ST_HI: begin
          hi_q  <= ssum;
          c12_q <= sc4;
          c16_q <= scout;
          ovf_q <= sovf;
        end
        ST_DONE: begin
          result    <= res_w;
          flags_out <= nf;
          rsp_valid <= 1'b1;
        end
        default: ;
      endcase
    end
  end

endmodule

`default_nettype wire
